// File: rtl/ddr3_video_pkg.sv
// Shared constants and types for the DDR3 video read/write paths.
package ddr3_video_pkg;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b000;

  // Displayed frame geometry.
  localparam int unsigned H_DATA = 1920;
  localparam int unsigned V_DATA = 1080;
  localparam int unsigned BPP    = 16;

  // Width of one app data beat.
  localparam int unsigned APP_DATA_W = 128;

  localparam int unsigned FRAME_BEATS = H_DATA * V_DATA * BPP / APP_DATA_W;
  // app_addr counts 16-bit words, so one beat advances by APP_DATA_W/16.
  localparam int unsigned ADDR_STEP = APP_DATA_W / 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WAIT_SPACE,
    ST_ISSUE,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a falling-edge detector.
// History resets high so an idle-high sync line gives no edge at reset.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic [1:0] sync;
  logic       prev;

  // Bring din into the clk domain and keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      prev <= sync[1];
    end
  end

  assign fall = prev & ~sync[1];

endmodule

// File: rtl/ddr3_frame_reader.sv
// Read-side frame fetcher: issues DDR3 app read commands for one frame and
// forwards returned beats into the read-data FIFO, realigning on every vsync.
module ddr3_frame_reader #(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FRAME_BEATS = ddr3_video_pkg::FRAME_BEATS,
  parameter int unsigned ADDR_STEP   = ddr3_video_pkg::ADDR_STEP,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned CNT_W       = 10
) (
  input  logic              Sys_clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              vs_in,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic [CNT_W-1:0]  fifo_wr_cnt,
  output logic              fifo_flush,
  output logic              frame_done
);

  import ddr3_video_pkg::*;

  localparam int unsigned OUT_W   = CNT_W + 1;
  localparam int unsigned SUM_W   = CNT_W + 2;
  localparam int unsigned BEAT_W  = $clog2(FRAME_BEATS + 1);
  localparam int unsigned BURST_W = $clog2(BURST_LEN + 1);

  rd_state_e          state;
  logic [OUT_W-1:0]   outstanding;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               vs_fall;
  logic               accept;
  logic               rd_take;
  logic               forward;
  logic               space_ok;

  sync_edge_det u_vs_det (
    .clk   (Sys_clk),
    .rst_n (Rst_n),
    .din   (vs_in),
    .fall  (vs_fall)
  );

  assign app_cmd = CMD_READ;
  assign accept  = app_en & app_rdy;
  // Returns with nothing outstanding are stray and neither counted nor kept.
  assign rd_take = app_rd_data_valid && (outstanding != '0);
  assign space_ok = (SUM_W'(fifo_wr_cnt) + SUM_W'(outstanding) + SUM_W'(BURST_LEN))
                    <= SUM_W'(FIFO_DEPTH);

  // Data is only forwarded once the FIFO has been realigned to this frame.
  always_comb begin
    forward = 1'b0;
    if (state inside {ST_WAIT_SPACE, ST_ISSUE, ST_DONE})
      forward = rd_take;
  end

  // Track commands issued but not yet returned.
  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, rd_take})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Register returned beats into the FIFO write port.
  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_en <= forward;
      if (forward)
        fifo_wr_data <= app_rd_data;
    end
  end

  // Frame command sequencer with registered command/flush/done outputs.
  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      app_en     <= 1'b0;
      app_addr   <= '0;
      fifo_flush <= 1'b0;
      frame_done <= 1'b0;
      beat_cnt   <= '0;
      burst_cnt  <= '0;
    end else begin
      fifo_flush <= 1'b0;
      // A new vsync abandons the frame; any command accepted this very cycle
      // is still counted as outstanding and drained in FLUSH.
      if (vs_fall && (state inside {ST_WAIT_SPACE, ST_ISSUE, ST_DONE})) begin
        state  <= ST_FLUSH;
        app_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (vs_fall)
              state <= ST_FLUSH;
          end
          ST_FLUSH: begin
            app_en <= 1'b0;
            if (outstanding == '0) begin
              fifo_flush <= 1'b1;
              app_addr   <= frame_base;
              beat_cnt   <= '0;
              frame_done <= 1'b0;
              state      <= ST_WAIT_SPACE;
            end
          end
          ST_WAIT_SPACE: begin
            if (space_ok) begin
              app_en    <= 1'b1;
              burst_cnt <= '0;
              state     <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (app_rdy) begin
              app_addr  <= app_addr + ADDR_W'(ADDR_STEP);
              burst_cnt <= burst_cnt + 1'b1;
              beat_cnt  <= beat_cnt + 1'b1;
              if (beat_cnt == BEAT_W'(FRAME_BEATS - 1)) begin
                app_en     <= 1'b0;
                frame_done <= 1'b1;
                state      <= ST_DONE;
              end else if (burst_cnt == BURST_W'(BURST_LEN - 1)) begin
                app_en <= 1'b0;
                state  <= ST_WAIT_SPACE;
              end
            end
          end
          ST_DONE: begin
            app_en <= 1'b0;
          end
          default: begin
            app_en <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Directed bench for ddr3_frame_reader with a small frame and FIFO.
module tb_ddr3_frame_reader;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic [27:0]   frame_base;
  logic          vs_in;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [27:0]   app_addr;
  logic          app_rdy;
  logic [127:0]  app_rd_data;
  logic          app_rd_data_valid;
  logic          fifo_wr_en;
  logic [127:0]  fifo_wr_data;
  logic [9:0]    fifo_wr_cnt;
  logic          fifo_flush;
  logic          frame_done;

  int            n_checks = 0;
  int            n_err    = 0;
  int            acc_cnt  = 0;
  int            wr_cnt   = 0;
  int            flush_cnt = 0;
  int            en_hi;
  int            f0, f1, w0;
  bit            resp_en = 1'b0;
  bit            fwd_expect = 1'b1;
  logic [27:0]   exp_addr;
  logic [27:0]   cur_base;
  logic [27:0]   last_addr = '0;
  logic [27:0]   pend_q[$];
  logic [27:0]   addr_log[$];

  ddr3_frame_reader #(
    .ADDR_W      (28),
    .DATA_W      (128),
    .BURST_LEN   (16),
    .FRAME_BEATS (256),
    .ADDR_STEP   (8),
    .FIFO_DEPTH  (64),
    .CNT_W       (10)
  ) dut (
    .Sys_clk           (sys_clk),
    .Rst_n             (rst_n),
    .frame_base        (frame_base),
    .vs_in             (vs_in),
    .app_en            (app_en),
    .app_cmd           (app_cmd),
    .app_addr          (app_addr),
    .app_rdy           (app_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .fifo_wr_en        (fifo_wr_en),
    .fifo_wr_data      (fifo_wr_data),
    .fifo_wr_cnt       (fifo_wr_cnt),
    .fifo_flush        (fifo_flush),
    .frame_done        (frame_done)
  );

  initial forever #5 sys_clk = ~sys_clk;

  function automatic logic [127:0] mk_data(input logic [27:0] a);
    return {4{4'hA, a}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Commit current inputs, advance to the next negedge and observe outputs.
  task automatic tick();
    bit           acc, drove, stall_now;
    logic [127:0] dd;
    logic [27:0]  stall_a;
    acc   = app_en && app_rdy;
    drove = 1'b0;
    dd    = '0;
    if (resp_en && pend_q.size() > 0) begin
      dd    = mk_data(pend_q.pop_front());
      drove = 1'b1;
    end
    app_rd_data_valid = drove;
    app_rd_data       = dd;
    if (acc) begin
      chk("cmd_addr_seq", app_addr, exp_addr);
      exp_addr  = exp_addr + 28'd8;
      acc_cnt++;
      last_addr = app_addr;
      addr_log.push_back(app_addr);
      pend_q.push_back(app_addr);
    end
    stall_now = app_en && !app_rdy;
    stall_a   = app_addr;
    @(negedge sys_clk);
    if (stall_now && app_en) chk("addr_hold", app_addr, stall_a);
    if (drove || fifo_wr_en) chk("fwd_en", fifo_wr_en, drove && fwd_expect);
    if (fifo_wr_en) begin
      wr_cnt++;
      chk("fwd_data", fifo_wr_data, dd);
    end
    if (fifo_flush) begin
      flush_cnt++;
      exp_addr = cur_base;
    end
  endtask

  task automatic vs_pulse();
    vs_in = 1'b0;
    repeat (3) tick();
    vs_in = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    vs_in = 1'b1;
    app_rdy = 1'b0;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    fifo_wr_cnt = '0;
    frame_base = 28'h100;
    cur_base = 28'h100;
    exp_addr = 28'h100;
    repeat (3) tick();

    // Reset state
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_app_addr", app_addr, 28'h0);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_wr_data", fifo_wr_data, 128'h0);
    chk("rst_flush", fifo_flush, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("app_cmd", app_cmd, 3'b001);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_no_flush", flush_cnt, 0);
    chk("idle_no_en", app_en, 1'b0);

    // Frame start, no returns: FIFO holds 1 word so the 4th burst needs 65 > 64
    app_rdy = 1'b1;
    fifo_wr_cnt = 10'd1;
    vs_pulse();
    repeat (150) tick();
    chk("t1_flush_once", flush_cnt, 1);
    chk("t1_acc_48", acc_cnt, 48);
    chk("t1_first_addr", addr_log[0], 28'h100);
    chk("t1_burst_end", addr_log[15], 28'h178);
    chk("t1_last_addr", last_addr, 28'h278);
    chk("t1_stalled", app_en, 1'b0);
    chk("t1_no_data", wr_cnt, 0);
    // Empty FIFO: 0+48+16 = 64 is exactly allowed, then 64+16 stalls
    fifo_wr_cnt = 10'd0;
    repeat (60) tick();
    chk("t1_acc_64", acc_cnt, 64);
    chk("t1_last_addr64", last_addr, 28'h2F8);
    chk("t1_stalled64", app_en, 1'b0);

    // Returns enabled, app_rdy toggling 1-0-1
    resp_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      app_rdy = (i % 2 == 0);
      tick();
    end
    app_rdy = 1'b1;
    for (int i = 0; i < 600 && !frame_done; i++) tick();

    // Full frame
    chk("t4_done", frame_done, 1'b1);
    chk("t4_acc_256", acc_cnt, 256);
    chk("t4_last_addr", last_addr, 28'h8F8);
    en_hi = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (app_en) en_hi++;
    end
    chk("t4_en_quiet", en_hi, 0);
    chk("t4_wr_256", wr_cnt, 256);
    chk("t4_drained", pend_q.size(), 0);
    chk("t4_done_held", frame_done, 1'b1);

    // vs_fall mid-burst with 10 outstanding
    resp_en = 1'b0;
    acc_cnt = 0;
    f0 = flush_cnt;
    vs_pulse();
    for (int i = 0; i < 100 && acc_cnt < 10; i++) tick();
    app_rdy = 1'b0;
    chk("t5_acc_10", acc_cnt, 10);
    chk("t5_flush_start", flush_cnt, f0 + 1);
    chk("t5_done_clear", frame_done, 1'b0);
    vs_pulse();
    repeat (6) tick();
    chk("t5_en_off", app_en, 1'b0);
    chk("t5_no_new_cmd", acc_cnt, 10);
    chk("t5_no_early_flush", flush_cnt, f0 + 1);
    fwd_expect = 1'b0;
    w0 = wr_cnt;
    resp_en = 1'b1;
    for (int i = 0; i < 30 && pend_q.size() > 0; i++) tick();
    chk("t5_returned", pend_q.size(), 0);
    chk("t5_flush_wait", flush_cnt, f0 + 1);
    chk("t5_discarded", wr_cnt, w0);
    tick();
    chk("t5_flush_after", flush_cnt, f0 + 2);
    fwd_expect = 1'b1;
    app_rdy = 1'b1;
    acc_cnt = 0;
    addr_log.delete();
    for (int i = 0; i < 20 && acc_cnt < 1; i++) tick();
    chk("t5_restart_acc", acc_cnt > 0, 1'b1);
    chk("t5_restart_addr", addr_log[0], 28'h100);

    // Reset during ISSUE
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_app_en", app_en, 1'b0);
    chk("t6_app_addr", app_addr, 28'h0);
    chk("t6_wr_en", fifo_wr_en, 1'b0);
    chk("t6_wr_data", fifo_wr_data, 128'h0);
    chk("t6_flush", fifo_flush, 1'b0);
    chk("t6_done", frame_done, 1'b0);
    pend_q.delete();
    resp_en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    acc_cnt = 0;
    f1 = flush_cnt;
    en_hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (app_en) en_hi++;
    end
    chk("t6_quiet_en", en_hi, 0);
    chk("t6_quiet_acc", acc_cnt, 0);
    chk("t6_quiet_flush", flush_cnt, f1);
    frame_base = 28'h2000;
    cur_base = 28'h2000;
    addr_log.delete();
    vs_pulse();
    for (int i = 0; i < 30 && acc_cnt < 1; i++) tick();
    chk("t6_flush_after_vs", flush_cnt, f1 + 1);
    chk("t6_new_base", addr_log[0], 28'h2000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
